// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial receiver for start + 4 data + parity + stop frames.
// Outputs a..d/p (LSB first) feed the downstream odd-parity checker.
// Ports: clk, rst_n (async, active low), rx (idles high),
//        a,b,c,d,p (held frame bits), valid / frame_err (1-cycle strobes),
//        busy (receiver not idle).
// Option: define PARITY_FRAME_RX_SYNC_EN to pass rx through a 2-flop
//         synchroniser first (all timing shifts 2 cycles later).
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic p,
    output logic valid,
    output logic frame_err,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       idx, idx_nx;
    logic [3:0]       sr, sr_nx;
    logic             par, par_nx;
    logic             load, ferr_nx;
    logic             rx_in, rx_prev;
    logic             tick_half, tick_full;

`ifdef PARITY_FRAME_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_in = sync_q[1];
`else
    assign rx_in = rx;
`endif

    assign tick_half = (cnt == HALF_M1);
    assign tick_full = (cnt == FULL_M1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sr_nx    = sr;
        par_nx   = par;
        load     = 1'b0;
        ferr_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                // falling edge only; a line already low never starts
                if (rx_prev && !rx_in) begin
                    state_nx = START;
                end
            end
            START: begin
                if (tick_half) begin
                    cnt_nx   = '0;
                    idx_nx   = 2'd0;
                    state_nx = rx_in ? IDLE : DATA;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (tick_full) begin
                    cnt_nx      = '0;
                    sr_nx[idx]  = rx_in;
                    idx_nx      = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_nx = PARITY;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (tick_full) begin
                    cnt_nx   = '0;
                    par_nx   = rx_in;
                    state_nx = STOP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (tick_full) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    load     = rx_in;
                    ferr_nx  = !rx_in;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 2'd0;
            sr        <= 4'd0;
            par       <= 1'b0;
            rx_prev   <= 1'b1;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            d         <= 1'b0;
            p         <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            sr        <= sr_nx;
            par       <= par_nx;
            rx_prev   <= rx_in;
            valid     <= load;
            frame_err <= ferr_nx;
            if (load) begin
                a <= sr[0];
                b <= sr[1];
                c <= sr[2];
                d <= sr[3];
                p <= par;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed bench for parity_frame_rx.
// Frames are driven bit-by-bit; strobes are logged on the falling edge.
module tb_parity_frame_rx;

`ifdef PARITY_FRAME_RX_SYNC_EN
    localparam int LAT = 54;
`else
    localparam int LAT = 52;
`endif
    localparam int SH = LAT - 52;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic a, b, c, d, p, valid, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [4:0] vq[$];
    int         vcq[$];
    int         fcq[$];
    int         both_cnt = 0;
    int         busy_n = 0;
    int         busy_last = 0;

    parity_frame_rx #(.CLKS_PER_BIT(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .a(a), .b(b), .c(c), .d(d), .p(p),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vq.push_back({a, b, c, d, p});
            vcq.push_back(cyc);
        end
        if (frame_err) fcq.push_back(cyc);
        if (valid && frame_err) both_cnt++;
        if (busy) begin
            busy_n++;
            busy_last = cyc;
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // dat[0] is sent first
    task automatic send_frame(input logic [3:0] dat, input logic par,
                              input logic stp, output int t0);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(dat[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    task automatic chk_out(input string nm, input logic [4:0] want);
        checks++;
        if ({a, b, c, d, p} !== want) begin
            errors++;
            $display("FAIL %s: abcdp got %b want %b", nm, {a, b, c, d, p}, want);
        end
    endtask

    task automatic test_reset();
        int bad;
        int bn;
        bad = 0;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({a, b, c, d, p, valid, frame_err, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: got %b want 00000000",
                     {a, b, c, d, p, valid, frame_err, busy});
        end
        bn = busy_n;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({a, b, c, d, p, valid, frame_err, busy} !== 8'h00) bad++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet: nonzero cycles %0d want 0", bad);
        end
        checks++;
        if (vq.size() + fcq.size() != 0 || busy_n != bn) begin
            errors++;
            $display("FAIL idle_strobes: got %0d want 0", vq.size() + fcq.size());
        end
    endtask

    task automatic test_frame();
        int t0;
        int vb;
        int fb;
        vb = vq.size();
        fb = fcq.size();
        send_frame(4'b1101, 1'b0, 1'b1, t0);
        idle(4);
        checks++;
        if (vq.size() - vb != 1) begin
            errors++;
            $display("FAIL frame_count: got %0d want 1", vq.size() - vb);
        end else begin
            checks++;
            if (vcq[vb] != t0 + LAT) begin
                errors++;
                $display("FAIL frame_time: got %0d want %0d", vcq[vb] - t0, LAT);
            end
            checks++;
            if (vq[vb] !== 5'b10110) begin
                errors++;
                $display("FAIL frame_data: got %b want 10110", vq[vb]);
            end
        end
        chk_out("frame_hold", 5'b10110);
        checks++;
        if ((^{a, b, c, d, p}) !== 1'b1) begin
            errors++;
            $display("FAIL frame_pec: got %b want 1", ^{a, b, c, d, p});
        end
        checks++;
        if (fcq.size() != fb) begin
            errors++;
            $display("FAIL frame_noerr: got %0d want 0", fcq.size() - fb);
        end
    endtask

    task automatic test_glitch();
        int t0;
        int bn;
        int vb;
        int fb;
        bn = busy_n;
        vb = vq.size();
        fb = fcq.size();
        t0 = cyc + 1;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        checks++;
        if (busy_n - bn != 4 || busy_last != t0 + SH + 3) begin
            errors++;
            $display("FAIL glitch_busy: cycles %0d last %0d want 4 last %0d",
                     busy_n - bn, busy_last - t0, SH + 3);
        end
        checks++;
        if (vq.size() != vb || fcq.size() != fb) begin
            errors++;
            $display("FAIL glitch_strobe: got %0d want 0",
                     vq.size() - vb + fcq.size() - fb);
        end
        chk_out("glitch_hold", 5'b10110);
    endtask

    task automatic test_frame_err();
        int t0;
        int vb;
        int fb;
        vb = vq.size();
        fb = fcq.size();
        send_frame(4'b0110, 1'b1, 1'b0, t0);
        idle(4);
        checks++;
        if (fcq.size() - fb != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d want 1", fcq.size() - fb);
        end else begin
            checks++;
            if (fcq[fb] != t0 + LAT) begin
                errors++;
                $display("FAIL ferr_time: got %0d want %0d", fcq[fb] - t0, LAT);
            end
        end
        checks++;
        if (vq.size() != vb) begin
            errors++;
            $display("FAIL ferr_novalid: got %0d want 0", vq.size() - vb);
        end
        chk_out("ferr_hold", 5'b10110);
    endtask

    task automatic test_back_to_back();
        int t0a;
        int t0b;
        int vb;
        vb = vq.size();
        idle(4);
        send_frame(4'b0011, 1'b1, 1'b1, t0a);
        send_frame(4'b1010, 1'b0, 1'b1, t0b);
        idle(4);
        checks++;
        if (vq.size() - vb != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", vq.size() - vb);
        end else begin
            checks++;
            if (vcq[vb] != t0a + LAT || vq[vb] !== 5'b11001) begin
                errors++;
                $display("FAIL b2b_first: got %b at %0d want 11001 at %0d",
                         vq[vb], vcq[vb] - t0a, LAT);
            end
            checks++;
            if (vcq[vb+1] != t0b + LAT || vq[vb+1] !== 5'b01010) begin
                errors++;
                $display("FAIL b2b_second: got %b at %0d want 01010 at %0d",
                         vq[vb+1], vcq[vb+1] - t0b, LAT);
            end
        end
        chk_out("b2b_hold", 5'b01010);
    endtask

    task automatic test_reset_mid();
        int t0;
        int t1;
        int vb;
        int fb;
        vb = vq.size();
        fb = fcq.size();
        fork
            send_frame(4'b1110, 1'b1, 1'b1, t0);
            begin
                repeat (31) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({a, b, c, d, p, valid, frame_err, busy} !== 8'h00) begin
                    errors++;
                    $display("FAIL rstmid_clear: got %b want 00000000",
                             {a, b, c, d, p, valid, frame_err, busy});
                end
                @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
        join
        idle(10);
        checks++;
        if (vq.size() != vb || fcq.size() != fb) begin
            errors++;
            $display("FAIL rstmid_strobe: got %0d want 0",
                     vq.size() - vb + fcq.size() - fb);
        end
        chk_out("rstmid_hold", 5'b00000);
        vb = vq.size();
        send_frame(4'b1001, 1'b1, 1'b1, t1);
        idle(4);
        checks++;
        if (vq.size() - vb != 1) begin
            errors++;
            $display("FAIL rstmid_next: got %0d frames want 1", vq.size() - vb);
        end else begin
            checks++;
            if (vcq[vb] != t1 + LAT || vq[vb] !== 5'b10011) begin
                errors++;
                $display("FAIL rstmid_data: got %b at %0d want 10011 at %0d",
                         vq[vb], vcq[vb] - t1, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL strobe_excl: both high %0d want 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
